// File: rtl/sram_port_master.sv
// Round-robin initiator for one SRAM port with in-order read returns through a
// 2-entry response buffer, plus an optional zero-fill sweep after reset.
module sram_port_master #(
   parameter int CLIENTS        = 2,
   parameter int WIDTH          = 32,
   parameter int DEPTH          = 8,
   parameter int CLEAR_ON_RESET = 1,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int IW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [CLIENTS-1:0] i_req_valid,
   output logic [CLIENTS-1:0] o_req_ready,
   input  logic [CLIENTS-1:0] i_req_write,
   input  logic [AW-1:0]      i_req_addr   [0:CLIENTS-1],
   input  logic [WIDTH-1:0]   i_req_w_data [0:CLIENTS-1],
   output logic               o_rsp_valid,
   output logic [IW-1:0]      o_rsp_id,
   output logic [WIDTH-1:0]   o_rsp_data,
   input  logic               i_rsp_ready,
   output logic               o_sram_e,
   output logic               o_sram_w_e,
   output logic [AW-1:0]      o_sram_addr,
   output logic [WIDTH-1:0]   o_sram_w_data,
   input  logic [WIDTH-1:0]   i_sram_r_data,
   output logic               o_init_done
);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic             inflight_q;
   logic [IW-1:0]    inflight_id_q;
   logic [WIDTH-1:0] fifo_data_q [0:1];
   logic [IW-1:0]    fifo_id_q   [0:1];
   logic             rd_ptr_q, wr_ptr_q;
   logic [1:0]       count_q, count_d;

   logic               run;
   logic               read_credit;
   logic [2:0]         occupancy;
   logic [CLIENTS-1:0] eligible;
   logic               grant_any;
   logic [IW-1:0]      grant_idx;
   logic               issue_read;
   logic               fifo_empty, bypass, rsp_pop, push, fifo_pop;

   assign run         = !i_rst && (state_q == ST_RUN);
   // Credit counts the buffer before this cycle's dequeue plus the read already on the port.
   assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q};
   assign read_credit = (occupancy < 3'd2);

   generate
      for (genvar gi = 0; gi < CLIENTS; gi++) begin : g_client
         assign eligible[gi]    = run && i_req_valid[gi] && (i_req_write[gi] || read_credit);
         assign o_req_ready[gi] = grant_any && (grant_idx == IW'(gi));
      end
   endgenerate

   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < CLIENTS; k++) begin
         idx = (int'(rr_ptr_q) + k) % CLIENTS;
         if (!grant_any && eligible[idx]) begin
            grant_any = 1'b1;
            grant_idx = IW'(idx);
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any) begin
         rr_ptr_d = (grant_idx == IW'(CLIENTS - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   assign issue_read = grant_any && !i_req_write[grant_idx];

   always_comb begin
      o_sram_e      = 1'b0;
      o_sram_w_e    = 1'b0;
      o_sram_addr   = '0;
      o_sram_w_data = '0;
      if (!i_rst && state_q == ST_CLEAR) begin
         o_sram_e    = 1'b1;
         o_sram_w_e  = 1'b1;
         o_sram_addr = clr_cnt_q;
      end else if (grant_any) begin
         o_sram_e      = 1'b1;
         o_sram_w_e    = i_req_write[grant_idx];
         o_sram_addr   = i_req_addr[grant_idx];
         o_sram_w_data = i_req_w_data[grant_idx];
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == ST_CLEAR) begin
         if (clr_cnt_q == AW'(DEPTH - 1)) begin
            state_d   = ST_RUN;
            clr_cnt_d = '0;
         end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
         end
      end
   end

   assign o_init_done = (CLEAR_ON_RESET == 0) || run;

   // An empty buffer lets returning read data flow straight to the response port.
   assign fifo_empty  = (count_q == 2'd0);
   assign bypass      = fifo_empty && inflight_q;
   assign o_rsp_valid = !i_rst && (!fifo_empty || inflight_q);
   assign o_rsp_data  = !o_rsp_valid ? '0 : (fifo_empty ? i_sram_r_data : fifo_data_q[rd_ptr_q]);
   assign o_rsp_id    = !o_rsp_valid ? '0 : (fifo_empty ? inflight_id_q : fifo_id_q[rd_ptr_q]);
   assign rsp_pop     = o_rsp_valid && i_rsp_ready;
   assign push        = inflight_q && !(bypass && rsp_pop);
   assign fifo_pop    = rsp_pop && !fifo_empty;
   assign count_d     = count_q + {1'b0, push} - {1'b0, fifo_pop};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         clr_cnt_q     <= '0;
         rr_ptr_q      <= '0;
         inflight_q    <= 1'b0;
         inflight_id_q <= '0;
         rd_ptr_q      <= 1'b0;
         wr_ptr_q      <= 1'b0;
         count_q       <= 2'd0;
      end else begin
         state_q       <= state_d;
         clr_cnt_q     <= clr_cnt_d;
         rr_ptr_q      <= rr_ptr_d;
         inflight_q    <= issue_read;
         inflight_id_q <= grant_idx;
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
         count_q       <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst && push) begin
         fifo_data_q[wr_ptr_q] <= i_sram_r_data;
         fifo_id_q[wr_ptr_q]   <= inflight_id_q;
      end
   end

endmodule

// File: tb/tb_sram_port_master.sv
// Self-checking bench for sram_port_master: behavioural SRAM, reference memory
// and a response scoreboard filled at request acceptance.
module tb_sram_port_master;

   localparam int CLIENTS = 2;
   localparam int WIDTH   = 32;
   localparam int DEPTH   = 8;
   localparam int AW      = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [CLIENTS-1:0] req_valid = '0;
   logic [CLIENTS-1:0] req_ready;
   logic [CLIENTS-1:0] req_write = '0;
   logic [AW-1:0]      req_addr   [0:CLIENTS-1];
   logic [WIDTH-1:0]   req_w_data [0:CLIENTS-1];
   logic               rsp_valid;
   logic [0:0]         rsp_id;
   logic [WIDTH-1:0]   rsp_data;
   logic               rsp_ready = 1'b1;
   logic               sram_e, sram_w_e;
   logic [AW-1:0]      sram_addr;
   logic [WIDTH-1:0]   sram_w_data;
   logic [WIDTH-1:0]   sram_r_data = '0;
   logic               init_done;

   logic [WIDTH-1:0] sram_mem [0:DEPTH-1];
   logic [WIDTH-1:0] ref_mem  [0:DEPTH-1];

   typedef struct {
      logic [0:0]       id;
      logic [WIDTH-1:0] data;
   } exp_t;
   exp_t sb_q[$];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sram_port_master #(
      .CLIENTS(CLIENTS), .WIDTH(WIDTH), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
      .i_req_addr(req_addr), .i_req_w_data(req_w_data),
      .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_data(rsp_data),
      .i_rsp_ready(rsp_ready),
      .o_sram_e(sram_e), .o_sram_w_e(sram_w_e), .o_sram_addr(sram_addr),
      .o_sram_w_data(sram_w_data), .i_sram_r_data(sram_r_data),
      .o_init_done(init_done)
   );

   // Registered-read SRAM, preloaded with garbage so the clear sweep matters.
   initial begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] = 32'hA5A5_0000 + i;
   end
   always @(posedge clk) begin
      if (sram_e) begin
         if (sram_w_e) sram_mem[sram_addr] <= sram_w_data;
         else          sram_r_data <= sram_mem[sram_addr];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: sampled late in each cycle, after inputs and outputs have settled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #4;
         if (rst) begin
            sb_q.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
         end else begin
            if (rsp_valid && rsp_ready) begin
               if (sb_q.size() == 0) begin
                  chk("rsp_unexpected", 64'd1, 64'd0);
               end else begin
                  e = sb_q.pop_front();
                  chk("rsp_id", rsp_id, e.id);
                  chk("rsp_data", rsp_data, e.data);
                  $display("rsp id=%0d data=%08h", rsp_id, rsp_data);
               end
            end
            for (int c = 0; c < CLIENTS; c++) begin
               if (req_valid[c] && req_ready[c]) begin
                  if (req_write[c]) begin
                     ref_mem[req_addr[c]] = req_w_data[c];
                     $display("wr client=%0d addr=%0d data=%08h", c, req_addr[c], req_w_data[c]);
                  end else begin
                     e.id   = c[0:0];
                     e.data = ref_mem[req_addr[c]];
                     sb_q.push_back(e);
                     $display("rd client=%0d addr=%0d", c, req_addr[c]);
                  end
               end
            end
         end
      end
   end

   // Reset, then check the sweep; abort_at < DEPTH re-asserts reset at that address.
   task automatic sweep(input int abort_at);
      rst = 1'b1;
      req_valid = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_sram_e", sram_e, 0);
      chk("rst_sram_w_e", sram_w_e, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_init_done", init_done, 0);
      rst = 1'b0;
      req_valid = 2'b11;
      req_write = 2'b00;
      for (int k = 0; k < DEPTH; k++) begin
         #1;
         chk("clr_e", sram_e, 1);
         chk("clr_w_e", sram_w_e, 1);
         chk("clr_addr", sram_addr, k);
         chk("clr_w_data", sram_w_data, 0);
         chk("clr_ready", req_ready, 0);
         chk("clr_done", init_done, 0);
         $display("sweep addr=%0d", sram_addr);
         if (k == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      req_valid = '0;
      #1;
      chk("done_cycle9", init_done, 1);
      chk("run_idle_e", sram_e, 0);
   endtask

   initial begin
      for (int c = 0; c < CLIENTS; c++) begin
         req_addr[c]   = '0;
         req_w_data[c] = '0;
      end

      sweep(DEPTH);
      sweep(4);
      sweep(DEPTH);

      // Write then read-after-write from client 0.
      @(negedge clk);
      req_valid = 2'b01; req_write = 2'b01; req_addr[0] = 3; req_w_data[0] = 32'hDEADBEEF;
      #1 chk("wr_grant", req_ready, 2'b01);
      @(negedge clk);
      req_write = 2'b00;
      #1 chk("rd_grant", req_ready, 2'b01);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("raw_valid", rsp_valid, 1);
      chk("raw_data", rsp_data, 32'hDEADBEEF);
      chk("raw_id", rsp_id, 0);

      @(negedge clk);
      req_valid = 2'b10; req_write = 2'b10; req_addr[1] = 5; req_w_data[1] = 32'h5555AAAA;
      #1 chk("wr1_grant", req_ready, 2'b10);

      // Both clients reading back to back: alternating grants, one response per cycle.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         req_valid = 2'b11; req_write = 2'b00;
         req_addr[0] = 3;
         req_addr[1] = (i % 4 == 1) ? 3'd5 : 3'd7;
         #1;
         chk("rr_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
         chk("rr_rsp_valid", rsp_valid, (i != 0));
      end
      @(negedge clk);
      req_valid = 2'b00;
      #1 chk("rr_last_rsp", rsp_valid, 1);
      @(negedge clk);
      #1 chk("rr_drained", rsp_valid, 0);

      // Back-pressure: two reads fill the credit, writes still pass.
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 3;
      #1 chk("bp_rd0", req_ready, 2'b01);
      @(negedge clk);
      req_addr[0] = 5;
      #1 chk("bp_rd1", req_ready, 2'b01);
      @(negedge clk);
      #1 chk("bp_stall", req_ready, 2'b00);
      @(negedge clk);
      req_valid = 2'b11; req_write = 2'b10; req_addr[1] = 6; req_w_data[1] = 32'h66661234;
      #1 chk("bp_wr_pass", req_ready, 2'b10);
      @(negedge clk);
      req_valid = 2'b01; req_write = 2'b00;
      #1;
      chk("bp_stall2", req_ready, 2'b00);
      chk("bp_head_valid", rsp_valid, 1);
      chk("bp_head_data", rsp_data, 32'hDEADBEEF);
      @(negedge clk);
      req_valid = 2'b00; rsp_ready = 1'b1;
      #1 chk("bp_drain0", rsp_valid, 1);
      @(negedge clk);
      #1 chk("bp_drain1", rsp_valid, 1);
      @(negedge clk);
      #1 chk("bp_empty", rsp_valid, 0);

      @(negedge clk);
      req_valid = 2'b01; req_addr[0] = 6;
      #1 chk("rd6_grant", req_ready, 2'b01);
      @(negedge clk);
      req_valid = 2'b00;
      #1 chk("rd6_valid", rsp_valid, 1);

      // Reset with a read in flight: its response must never appear.
      @(negedge clk);
      req_valid = 2'b01; req_addr[0] = 3;
      #1 chk("fl_grant", req_ready, 2'b01);
      @(negedge clk);
      req_valid = 2'b00; rst = 1'b1;
      #1 chk("fl_rst_valid", rsp_valid, 0);
      sweep(DEPTH);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 chk("fl_no_rsp", rsp_valid, 0);
      end
      chk("sb_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sram_port_master.md
Name: sram_port_master

Overview:
- Initiator side of a single SRAM port with enable, write-enable, address, write data and registered read data (1-cycle latency).
- Accepts requests from CLIENTS requesters over valid/ready and arbitrates them round-robin onto the port, one per cycle.
- Returns read data in order on one shared response channel, with a 2-entry response buffer.
- Optionally zero-fills the whole array after reset before accepting traffic.

Parameters:
- CLIENTS, 2, number of requesters (>=1).
- WIDTH, 32, data width in bits.
- DEPTH, 8, SRAM entries; address width AW = $clog2(DEPTH).
- CLEAR_ON_RESET, 1, when 1, sweep-write zeros to all entries after reset.

Ports:
- i_clk  in  1  clock; all logic on its rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_req_valid  in  CLIENTS  per-client request valid.
- o_req_ready  out  CLIENTS  per-client request accepted this cycle (one-hot or zero).
- i_req_write  in  CLIENTS  per-client: 1 = write, 0 = read.
- i_req_addr  in  AW x [0:CLIENTS-1]  per-client address.
- i_req_w_data  in  WIDTH x [0:CLIENTS-1]  per-client write data.
- o_rsp_valid  out  1  read response available.
- o_rsp_id  out  $clog2(CLIENTS) (min 1)  index of the client that issued the read.
- o_rsp_data  out  WIDTH  read data.
- i_rsp_ready  in  1  consumer accepts the response.
- o_sram_e  out  1  SRAM port enable.
- o_sram_w_e  out  1  SRAM write enable.
- o_sram_addr  out  AW  SRAM address.
- o_sram_w_data  out  WIDTH  SRAM write data.
- i_sram_r_data  in  WIDTH  SRAM read data, valid the cycle after a read enable.
- o_init_done  out  1  high once the clear sweep is complete (or immediately if CLEAR_ON_RESET=0).

Behaviour:
- Reset values:
  - o_req_ready=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_data=0.
  - o_sram_e=0, o_sram_w_e=0.
  - o_init_done=0, or 1 when CLEAR_ON_RESET=0.
  - Round-robin pointer=0, response buffer empty, in-flight flag=0.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET, else RUN.
  - CLEAR: a counter walks addresses 0..DEPTH-1, one per cycle. Outputs are combinational from the counter: o_sram_e=1, o_sram_w_e=1, o_sram_w_data=0. o_req_ready stays 0.
  - After writing DEPTH-1, the FSM enters RUN; o_init_done goes 1 in the first RUN cycle. The sweep takes exactly DEPTH cycles.
  - Reset asserted during CLEAR restarts the sweep at address 0.
- Arbitration (RUN):
  - Eligible client: i_req_valid=1, and for reads, read credit available.
  - Grant goes to the first eligible client at or after the pointer, wrapping modulo CLIENTS.
  - On grant, the pointer moves to granted+1 (mod CLIENTS); with no grant it holds.
  - o_req_ready is combinational for the granted client. A request is accepted when valid && ready.
- Issue: the SRAM port is driven combinationally in the grant cycle with e=1, w_e=i_req_write, and the granted client's addr/data. With no grant, e=0 and w_e=0.
- Read credit: a read may issue only if (buffer occupancy + in-flight read) < 2, counted before this cycle's dequeue.
- Read return:
  - A read issued in cycle t sets the in-flight flag. At t+1, i_sram_r_data and the client id are pushed into the 2-entry FIFO.
  - The FIFO head drives o_rsp_*; it pops on o_rsp_valid && i_rsp_ready.
  - Push and pop in the same cycle keep the occupancy unchanged.
  - Sustained read throughput is 1 per cycle while i_rsp_ready=1.
- Ordering:
  - Responses return in issue order.
  - A write at t followed by a read of the same address at t+1 returns the new data.
  - Writes produce no response.
- Reset mid-traffic: an in-flight read is dropped, the FIFO is cleared, and no response appears for it.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=8, release reset -> o_sram_e/w_e high with addr 0..7 over 8 cycles, w_data=0, o_req_ready=0; o_init_done=1 on cycle 9.
- Client0 writes 0xDEADBEEF to addr 3, then reads addr 3 the next cycle -> o_rsp_valid one cycle after the read grant, o_rsp_data=0xDEADBEEF, o_rsp_id=0.
- Both clients hold valid reads continuously -> grants alternate 0,1,0,1; response ids alternate to match; one response per cycle with i_rsp_ready=1.
- i_rsp_ready=0 with client0 issuing reads -> exactly 2 reads accepted, then o_req_ready=0; writes from client1 are still granted; raising ready drains 2 responses in order.
- Read of an unwritten address after the clear sweep -> data 0x00000000.
- Reset asserted at sweep address 4 -> sweep restarts at 0, full 8 cycles; reset with one read in flight -> no o_rsp_valid afterwards.
